mc_ctrl: RTL and testbench

Multi-cycle control unit for the MIPS-subset CPU: the decode-and-steer side of the instruction fetch interface. Each cycle it receives the `Instr` word presented by the fetch unit and the ALU `Zero` flag. It returns `NPCOp`/`Br`/`PCWr` to the fetch unit, which chooses the next PC, and drives every datapath write enable and mux select. It sequences each instruction through FETCH/DECODE/EXE/MEM/WB states. The PC advances exactly once per instruction, in that instruction's last state.

---
 rtl/mc_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit for the MIPS-subset CPU: steps each instruction through
// FETCH/DECODE/EXE/MEM/WB and drives the fetch-side PC controls and datapath enables.
module mc_ctrl #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  output logic        PCWr,
  output logic [1:0]  NPCOp,
  output logic        Br,
  output logic        IRWr,
  output logic        RegWr,
  output logic [1:0]  RegDst,
  output logic        ALUSrc,
  output logic [2:0]  ALUOp,
  output logic        ExtOp,
  output logic        MemWr,
  output logic [1:0]  MemtoReg,
  output logic        Done,
  output logic [2:0]  State
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_NOP, I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JAL
  } kind_t;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JAL = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_LUI = 3'b011;

  state_t      state;
  state_t      nextstate;
  logic [31:0] ir;
  kind_t       kind;
  logic        unusedirbits;

  // Operand fields are consumed by the datapath, not by the controller.
  assign unusedirbits = ^ir[25:6];

  always_comb begin
    kind = I_NOP;
    case (ir[31:26])
      6'b000000: begin
        case (ir[5:0])
          6'b100001: kind = I_ADDU;
          6'b100011: kind = I_SUBU;
          6'b001000: kind = I_JR;
          default:   kind = I_NOP;
        endcase
      end
      6'b001101: kind = I_ORI;
      6'b001111: kind = I_LUI;
      6'b100011: kind = I_LW;
      6'b101011: kind = I_SW;
      6'b000100: kind = I_BEQ;
      6'b000011: kind = I_JAL;
      default:   kind = I_NOP;
    endcase
  end

  always_comb begin
    nextstate = FETCH;
    case (state)
      FETCH: nextstate = DECODE;
      DECODE: begin
        case (kind)
          I_JR, I_NOP: nextstate = FETCH;
          I_JAL:       nextstate = WB;
          default:     nextstate = EXE;
        endcase
      end
      EXE: begin
        case (kind)
          I_LW, I_SW:                    nextstate = MEM;
          I_ADDU, I_SUBU, I_ORI, I_LUI:  nextstate = WB;
          default:                       nextstate = FETCH;
        endcase
      end
      MEM:     nextstate = (kind == I_LW) ? WB : FETCH;
      default: nextstate = FETCH;
    endcase
  end

  // IR only captures in FETCH so later states decode a stable word.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state <= state_t'(RESET_STATE);
      ir    <= '0;
    end else begin
      state <= nextstate;
      if (state == FETCH) begin
        ir <= Instr;
      end
    end
  end

  always_comb begin
    PCWr     = 1'b0;
    NPCOp    = NPC_SEQ;
    Br       = 1'b0;
    IRWr     = 1'b0;
    RegWr    = 1'b0;
    RegDst   = 2'b00;
    ALUSrc   = 1'b0;
    ALUOp    = ALU_ADD;
    ExtOp    = 1'b0;
    MemWr    = 1'b0;
    MemtoReg = 2'b00;

    // ALU selects stay fixed from EXE through WB for the whole instruction.
    if (state == EXE || state == MEM || state == WB) begin
      case (kind)
        I_SUBU, I_BEQ: ALUOp = ALU_SUB;
        I_ORI: begin
          ALUOp  = ALU_OR;
          ALUSrc = 1'b1;
        end
        I_LUI: begin
          ALUOp  = ALU_LUI;
          ALUSrc = 1'b1;
        end
        I_LW, I_SW: begin
          ALUOp  = ALU_ADD;
          ALUSrc = 1'b1;
          ExtOp  = 1'b1;
        end
        default: ALUOp = ALU_ADD;
      endcase
    end

    case (state)
      FETCH: IRWr = 1'b1;
      DECODE: begin
        if (kind == I_JR) begin
          PCWr  = 1'b1;
          NPCOp = NPC_JR;
        end else if (kind == I_NOP) begin
          PCWr  = 1'b1;
        end
      end
      EXE: begin
        if (kind == I_BEQ) begin
          PCWr  = 1'b1;
          NPCOp = NPC_BR;
          Br    = Zero;
        end
      end
      MEM: begin
        if (kind == I_SW) begin
          MemWr = 1'b1;
          PCWr  = 1'b1;
        end
      end
      WB: begin
        RegWr = 1'b1;
        PCWr  = 1'b1;
        case (kind)
          I_ADDU, I_SUBU: RegDst = 2'b01;
          I_LW:           MemtoReg = 2'b01;
          I_JAL: begin
            NPCOp    = NPC_JAL;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
          end
          default: RegDst = 2'b00;
        endcase
      end
      default: IRWr = 1'b0;
    endcase

    // Holding reset low silences every output so an aborted instruction cannot write.
    if (!Reset) begin
      PCWr     = 1'b0;
      NPCOp    = NPC_SEQ;
      Br       = 1'b0;
      IRWr     = 1'b0;
      RegWr    = 1'b0;
      RegDst   = 2'b00;
      ALUSrc   = 1'b0;
      ALUOp    = ALU_ADD;
      ExtOp    = 1'b0;
      MemWr    = 1'b0;
      MemtoReg = 2'b00;
    end
  end

  assign Done  = PCWr;
  assign State = state;

endmodule

// File: tb/tb_mc_ctrl.sv
// Table-driven bench for mc_ctrl: per-cycle vectors with hand-computed outputs,
// plus cycle-count sequences for each instruction class.
module tb_mc_ctrl;

  logic        CLK;
  logic        Reset;
  logic [31:0] Instr;
  logic        Zero;
  logic        PCWr;
  logic [1:0]  NPCOp;
  logic        Br;
  logic        IRWr;
  logic        RegWr;
  logic [1:0]  RegDst;
  logic        ALUSrc;
  logic [2:0]  ALUOp;
  logic        ExtOp;
  logic        MemWr;
  logic [1:0]  MemtoReg;
  logic        Done;
  logic [2:0]  State;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ADDU = 32'h00851021;
  localparam logic [31:0] SUBU = 32'h00851023;
  localparam logic [31:0] ORI  = 32'h34A40010;
  localparam logic [31:0] LUI  = 32'h3C041234;
  localparam logic [31:0] LW   = 32'h8C880004;
  localparam logic [31:0] SW   = 32'hAC880008;
  localparam logic [31:0] BEQ  = 32'h1000FFFF;
  localparam logic [31:0] JAL  = 32'h0C000C00;
  localparam logic [31:0] JR   = 32'h03E00008;
  localparam logic [31:0] NOP  = 32'h00000000;
  localparam logic [31:0] ILL  = 32'hFC000000;
  localparam logic [31:0] J    = 32'hFFFFFFFF;

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic [2:0]  st;
    logic        pcwr;
    logic [1:0]  npc;
    logic        br;
    logic        irwr;
    logic        regwr;
    logic [1:0]  regdst;
    logic        memwr;
    logic [1:0]  m2r;
    logic [2:0]  aluop;
    logic        alusrc;
    logic        extop;
  } row_t;

  row_t rows[$];

  mc_ctrl #(.RESET_STATE(3'd0)) dut (
    .CLK(CLK), .Reset(Reset), .Instr(Instr), .Zero(Zero),
    .PCWr(PCWr), .NPCOp(NPCOp), .Br(Br), .IRWr(IRWr), .RegWr(RegWr),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .ExtOp(ExtOp),
    .MemWr(MemWr), .MemtoReg(MemtoReg), .Done(Done), .State(State)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic row_t mk(input logic rst, input logic [31:0] instr, input logic zero,
                              input logic [2:0] st, input logic pcwr, input logic [1:0] npc,
                              input logic br, input logic irwr, input logic regwr,
                              input logic [1:0] regdst, input logic memwr, input logic [1:0] m2r,
                              input logic [2:0] aluop, input logic alusrc, input logic extop);
    row_t r;
    r.rst = rst; r.instr = instr; r.zero = zero; r.st = st; r.pcwr = pcwr;
    r.npc = npc; r.br = br; r.irwr = irwr; r.regwr = regwr; r.regdst = regdst;
    r.memwr = memwr; r.m2r = m2r; r.aluop = aluop; r.alusrc = alusrc; r.extop = extop;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int idx, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // One cycle: drive inputs at the falling edge, let logic settle, compare.
  task automatic applyStimulus(input int idx, input row_t r);
    @(negedge CLK);
    Reset = r.rst;
    Instr = r.instr;
    Zero  = r.zero;
    #1;
    checkOutput("State", idx, 32'(State), 32'(r.st));
    checkOutput("PCWr",  idx, 32'(PCWr),  32'(r.pcwr));
    checkOutput("Done",  idx, 32'(Done),  32'(r.pcwr));
    checkOutput("IRWr",  idx, 32'(IRWr),  32'(r.irwr));
    checkOutput("RegWr", idx, 32'(RegWr), 32'(r.regwr));
    checkOutput("MemWr", idx, 32'(MemWr), 32'(r.memwr));
    checkOutput("Br",    idx, 32'(Br),    32'(r.br));
    checkOutput("OneWr", idx, 32'(RegWr & MemWr), 32'd0);
    if (r.rst) begin
      checkOutput("NPCOp",    idx, 32'(NPCOp),    32'(r.npc));
      checkOutput("RegDst",   idx, 32'(RegDst),   32'(r.regdst));
      checkOutput("MemtoReg", idx, 32'(MemtoReg), 32'(r.m2r));
      checkOutput("ALUOp",    idx, 32'(ALUOp),    32'(r.aluop));
      checkOutput("ALUSrc",   idx, 32'(ALUSrc),   32'(r.alusrc));
      checkOutput("ExtOp",    idx, 32'(ExtOp),    32'(r.extop));
    end
  endtask

  // Runs one instruction from FETCH until Done, with a bounded cycle budget.
  task automatic runInstr(input string name, input logic [31:0] instr, input logic zero,
                          input int expCycles, input logic [2:0] expAluOp,
                          input logic expAluSrc);
    int n;
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(negedge CLK);
      Reset = 1'b1;
      Instr = (n == 0) ? instr : J;
      Zero  = zero;
      #1;
      n++;
      if (Done) begin
        seen = 1'b1;
        checkOutput({name, ".ALUOp"},  n, 32'(ALUOp),  32'(expAluOp));
        checkOutput({name, ".ALUSrc"}, n, 32'(ALUSrc), 32'(expAluSrc));
        checkOutput({name, ".PCWr"},   n, 32'(PCWr),   32'd1);
      end
    end
    checkOutput({name, ".cycles"}, 0, 32'(n), 32'(expCycles));
  endtask

  initial begin
    Reset = 1'b0;
    Instr = 32'h0;
    Zero  = 1'b0;

    // rst instr zero st pcwr npc br irwr regwr regdst memwr m2r aluop alusrc extop
    rows.push_back(mk(1, ADDU, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 4, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, LW,   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    rows.push_back(mk(1, J,    0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    rows.push_back(mk(1, J,    0, 4, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 1));
    rows.push_back(mk(1, BEQ,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    rows.push_back(mk(1, BEQ,  1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 2, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    rows.push_back(mk(1, JAL,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 4, 1, 2, 0, 0, 1, 2, 0, 2, 0, 0, 0));
    rows.push_back(mk(1, JR,   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, SW,   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    rows.push_back(mk(1, J,    0, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    rows.push_back(mk(1, NOP,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, ILL,  0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // lw aborted by reset in MEM, then addu fetched normally
    rows.push_back(mk(1, LW,   0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    rows.push_back(mk(0, J,    0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, ADDU, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rows.push_back(mk(1, J,    0, 4, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));

    // Reset held low for three edges; enables must stay quiet throughout.
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1;
      checkOutput("rst.PCWr",  i, 32'(PCWr),  32'd0);
      checkOutput("rst.IRWr",  i, 32'(IRWr),  32'd0);
      checkOutput("rst.RegWr", i, 32'(RegWr), 32'd0);
      checkOutput("rst.MemWr", i, 32'(MemWr), 32'd0);
      checkOutput("rst.Done",  i, 32'(Done),  32'd0);
      checkOutput("rst.State", i, 32'(State), 32'd0);
    end

    for (int i = 0; i < rows.size(); i++) begin
      applyStimulus(i + 1, rows[i]);
    end

    runInstr("subu", SUBU, 0, 4, 3'b001, 1'b0);
    runInstr("ori",  ORI,  0, 4, 3'b010, 1'b1);
    runInstr("lui",  LUI,  0, 4, 3'b011, 1'b1);
    runInstr("lw",   LW,   0, 5, 3'b000, 1'b1);
    runInstr("sw",   SW,   0, 4, 3'b000, 1'b1);
    runInstr("beq",  BEQ,  1, 3, 3'b001, 1'b0);
    runInstr("jal",  JAL,  0, 3, 3'b000, 1'b0);
    runInstr("jr",   JR,   0, 2, 3'b000, 1'b0);
    runInstr("nop",  NOP,  0, 2, 3'b000, 1'b0);
    runInstr("ill",  ILL,  0, 2, 3'b000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
